// File: rtl/rv32i_types.sv
// Shared types for the CPU-side memory responder: arbiter states and port ids.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_arb_state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } mem_port_t;

endpackage

// File: rtl/split_mem_if.sv
// Bundle of the fetch port, data port and single-word physical memory port.
interface split_mem_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              read_a;
    logic [ADDR_W-1:0] address_a;
    logic              resp_a;
    logic [DATA_W-1:0] rdata_a;

    logic              read_b;
    logic              write;
    logic [MASK_W-1:0] wmask;
    logic [ADDR_W-1:0] address_b;
    logic [DATA_W-1:0] wdata;
    logic              resp_b;
    logic [DATA_W-1:0] rdata_b;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [DATA_W-1:0] pmem_wdata;
    logic [MASK_W-1:0] pmem_wmask;
    logic              pmem_resp;
    logic [DATA_W-1:0] pmem_rdata;

    logic              err;

    modport slave (
        input  read_a, address_a, read_b, write, wmask, address_b, wdata,
        input  pmem_resp, pmem_rdata,
        output resp_a, rdata_a, resp_b, rdata_b,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask, err
    );

    modport master (
        output read_a, address_a, read_b, write, wmask, address_b, wdata,
        output pmem_resp, pmem_rdata,
        input  resp_a, rdata_a, resp_b, rdata_b,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask, err
    );

endinterface

// File: rtl/split_mem_responder_watchdog.sv
// Counts stalled BUSY cycles; expired rises once the count reaches TIMEOUT_CYCLES (0 = never).
module mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;

    assign count_inc = count + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (enable && !expired) begin
            count   <= count_inc;
            expired <= (TIMEOUT_CYCLES != 0) && (count_inc == CNT_W'(TIMEOUT_CYCLES));
        end
    end

endmodule

// File: rtl/split_mem_responder.sv
// Arbitrates the fetch (A) and data (B) ports onto one physical memory port, one transaction at a time.
module split_mem_responder
    import rv32i_types::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic        clk,
    input logic        rst_n,
    split_mem_if.slave bus
);
    localparam int unsigned       MASK_W     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    mem_arb_state_t    state, state_d;
    mem_port_t         port_q, port_d;
    logic              write_q, write_d;
    logic              a_prio_q, a_prio_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic              pmem_read_q, pmem_read_d, pmem_write_q, pmem_write_d;
    logic              resp_a_q, resp_a_d, resp_b_q, resp_b_d;
    logic              err_q, err_d;
    logic              req_b, grant_a, expired;
    logic [DATA_W-1:0] done_data;

    // B normally wins, but a fetch that lost to B gets the next slot.
    assign req_b     = bus.read_b | bus.write;
    assign grant_a   = bus.read_a & (a_prio_q | ~req_b);
    assign done_data = bus.pmem_resp ? bus.pmem_rdata : '0;

    mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  ((state == BUSY) && !bus.pmem_resp),
        .clear   (state != BUSY),
        .expired (expired)
    );

    always_comb begin
        state_d      = state;
        port_d       = port_q;
        write_d      = write_q;
        a_prio_d     = a_prio_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        rdata_a_d    = rdata_a_q;
        rdata_b_d    = rdata_b_q;
        err_d        = err_q;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
        resp_a_d     = 1'b0;
        resp_b_d     = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_a) begin
                    port_d      = PORT_A;
                    write_d     = 1'b0;
                    a_prio_d    = 1'b0;
                    addr_d      = bus.address_a & ALIGN_MASK;
                    wdata_d     = '0;
                    wmask_d     = '0;
                    pmem_read_d = 1'b1;
                    state_d     = BUSY;
                end else if (req_b) begin
                    port_d       = PORT_B;
                    write_d      = bus.write;
                    a_prio_d     = bus.read_a;
                    addr_d       = bus.address_b & ALIGN_MASK;
                    wdata_d      = bus.wdata;
                    wmask_d      = bus.wmask;
                    pmem_read_d  = ~bus.write;
                    pmem_write_d = bus.write;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (bus.pmem_resp || expired) begin
                    state_d  = DONE;
                    resp_a_d = (port_q == PORT_A);
                    resp_b_d = (port_q == PORT_B);
                    // A timeout returns zero data even for a write.
                    if (!write_q || !bus.pmem_resp) begin
                        if (port_q == PORT_A) rdata_a_d = done_data;
                        else                  rdata_b_d = done_data;
                    end
                    if (!bus.pmem_resp) err_d = 1'b1;
                end else begin
                    pmem_read_d  = ~write_q;
                    pmem_write_d = write_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            port_q       <= PORT_A;
            write_q      <= 1'b0;
            a_prio_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
            err_q        <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            resp_a_q     <= 1'b0;
            resp_b_q     <= 1'b0;
        end else begin
            state        <= state_d;
            port_q       <= port_d;
            write_q      <= write_d;
            a_prio_q     <= a_prio_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
            err_q        <= err_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            resp_a_q     <= resp_a_d;
            resp_b_q     <= resp_b_d;
        end
    end

    assign bus.resp_a       = resp_a_q;
    assign bus.resp_b       = resp_b_q;
    assign bus.rdata_a      = rdata_a_q;
    assign bus.rdata_b      = rdata_b_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.pmem_wmask   = wmask_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_split_mem_responder.sv
// Randomized bench for split_mem_responder against a word-array memory model and port-level expectations.
module tb_split_mem_responder;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned TIMEOUT   = 8;
    localparam int unsigned MEM_WORDS = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    split_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    split_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] phys_mem [MEM_WORDS];
    logic [31:0] ref_mem  [MEM_WORDS];
    int unsigned lat_fixed = 1;
    bit          mem_hang  = 1'b0;
    int unsigned wait_cnt  = 0;
    int unsigned cur_lat   = 1;
    int unsigned txn_cnt   = 0;
    logic        log_write;
    logic [31:0] log_addr, log_wdata;
    logic [3:0]  log_wmask;
    logic [31:0] exp_rdata_a = '0;
    logic [31:0] exp_rdata_b = '0;
    bit          exp_err     = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drop_all();
        bus.read_a = 1'b0;
        bus.read_b = 1'b0;
        bus.write  = 1'b0;
    endtask

    // Backing memory: logs each transaction, answers after cur_lat cycles unless hung.
    initial begin
        int unsigned pidx;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.pmem_resp) begin
                bus.pmem_resp  = 1'b0;
                bus.pmem_rdata = '0;
                wait_cnt       = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (wait_cnt == 0) begin
                    txn_cnt++;
                    log_write = bus.pmem_write;
                    log_addr  = bus.pmem_address;
                    log_wdata = bus.pmem_wdata;
                    log_wmask = bus.pmem_wmask;
                    cur_lat   = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 6);
                end
                wait_cnt++;
                if (!mem_hang && wait_cnt >= cur_lat) begin
                    check_val("pmem_addr_stable", bus.pmem_address, log_addr);
                    check_val("pmem_op_stable", bus.pmem_write, log_write);
                    pidx = int'(bus.pmem_address[9:2]);
                    if (bus.pmem_write) begin
                        for (int j = 0; j < 4; j++)
                            if (bus.pmem_wmask[j]) phys_mem[pidx][8*j +: 8] = bus.pmem_wdata[8*j +: 8];
                    end else begin
                        bus.pmem_rdata = phys_mem[pidx];
                    end
                    bus.pmem_resp = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // One request on one port, held through its resp cycle (or dropped early while BUSY).
    task automatic run_single(input bit port_b, input bit is_write, input bit also_read,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wmask,
                              input int unsigned lat, input bit drop_early, input bit expect_timeout);
        int unsigned c0, n, t0, resp_cyc, idx, exp_lat;
        bit got, other;
        logic [31:0] got_data, exp_data;
        idx       = int'(addr[9:2]);
        lat_fixed = lat;
        t0        = txn_cnt;
        got = 1'b0; other = 1'b0; n = 0; resp_cyc = 0; got_data = '0;
        @(posedge clk); #1;
        if (!port_b) begin
            bus.read_a    = 1'b1;
            bus.address_a = addr;
        end else begin
            bus.read_b    = is_write ? also_read : 1'b1;
            bus.write     = is_write;
            bus.address_b = addr;
            bus.wdata     = wdata;
            bus.wmask     = wmask;
        end
        c0 = cyc;
        exp_lat = expect_timeout ? TIMEOUT + 2 : lat + 1;
        if (expect_timeout) begin
            exp_data = '0;
            exp_err  = 1'b1;
        end else if (port_b && is_write) begin
            exp_data = exp_rdata_b;
            for (int j = 0; j < 4; j++)
                if (wmask[j]) ref_mem[idx][8*j +: 8] = wdata[8*j +: 8];
        end else begin
            exp_data = ref_mem[idx];
        end
        if (port_b) exp_rdata_b = exp_data;
        else        exp_rdata_a = exp_data;

        while (!got && n < 64) begin
            @(negedge clk);
            if (port_b ? bus.resp_a : bus.resp_b) other = 1'b1;
            if (port_b ? bus.resp_b : bus.resp_a) begin
                got      = 1'b1;
                resp_cyc = cyc - c0;
                got_data = port_b ? bus.rdata_b : bus.rdata_a;
            end
            n++;
            if (!got && drop_early && n == 1) begin
                @(posedge clk); #1;
                drop_all();
            end
        end
        check_val("resp_seen", got, 1);
        check_val("resp_latency", resp_cyc, exp_lat);
        check_val("resp_rdata", got_data, exp_data);
        check_val("other_port_quiet", other, 0);
        check_val("err_flag", bus.err, exp_err);
        check_val("pmem_op", log_write, is_write);
        check_val("pmem_addr", log_addr, addr & 32'hFFFF_FFFC);
        if (is_write) begin
            check_val("pmem_wdata", log_wdata, wdata);
            check_val("pmem_wmask", log_wmask, wmask);
        end
        @(posedge clk); #1;
        drop_all();
        @(negedge clk);
        check_val("resp_one_cycle", port_b ? bus.resp_b : bus.resp_a, 0);
        repeat (3) @(negedge clk);
        check_val("txn_count", txn_cnt - t0, 1);
        check_val("rdata_held", port_b ? bus.rdata_b : bus.rdata_a, port_b ? exp_rdata_b : exp_rdata_a);
    endtask

    // Both ports request continuously: grants must alternate B, A, B, A.
    task automatic run_contention(input logic [31:0] addr_a, input logic [31:0] addr_b);
        bit seq[$];
        int unsigned n, t0, ia, ib;
        ia = int'(addr_a[9:2]);
        ib = int'(addr_b[9:2]);
        lat_fixed = 0;
        t0 = txn_cnt;
        n  = 0;
        @(posedge clk); #1;
        bus.read_a    = 1'b1;
        bus.address_a = addr_a;
        bus.read_b    = 1'b1;
        bus.write     = 1'b0;
        bus.address_b = addr_b;
        while (seq.size() < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.resp_b) begin
                seq.push_back(1'b1);
                check_val("contend_rdata_b", bus.rdata_b, ref_mem[ib]);
            end
            if (bus.resp_a) begin
                seq.push_back(1'b0);
                check_val("contend_rdata_a", bus.rdata_a, ref_mem[ia]);
            end
        end
        @(posedge clk); #1;
        drop_all();
        check_val("contend_resp_count", seq.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < seq.size()) check_val("contend_order", seq[i], (i % 2 == 0) ? 1 : 0);
        repeat (3) @(negedge clk);
        check_val("contend_txn_count", txn_cnt - t0, 4);
        exp_rdata_a = ref_mem[ia];
        exp_rdata_b = ref_mem[ib];
    endtask

    task automatic run_reset_mid_busy();
        bit seen;
        lat_fixed = 6;
        @(posedge clk); #1;
        bus.read_a    = 1'b1;
        bus.address_a = 32'h30;
        repeat (2) begin @(posedge clk); #1; end
        check_val("pre_reset_busy", bus.pmem_read, 1);
        rst_n = 1'b0;
        #1;
        check_val("rst_resp_a", bus.resp_a, 0);
        check_val("rst_resp_b", bus.resp_b, 0);
        check_val("rst_rdata_a", bus.rdata_a, 0);
        check_val("rst_rdata_b", bus.rdata_b, 0);
        check_val("rst_pmem_read", bus.pmem_read, 0);
        check_val("rst_pmem_write", bus.pmem_write, 0);
        check_val("rst_pmem_address", bus.pmem_address, 0);
        check_val("rst_pmem_wdata", bus.pmem_wdata, 0);
        check_val("rst_pmem_wmask", bus.pmem_wmask, 0);
        check_val("rst_err", bus.err, 0);
        @(posedge clk); #1;
        drop_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_rdata_a = '0;
        exp_rdata_b = '0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_a || bus.resp_b) seen = 1'b1;
        end
        check_val("no_resp_after_reset", seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        drop_all();
        bus.address_a = '0;
        bus.address_b = '0;
        bus.wdata     = '0;
        bus.wmask     = '0;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            phys_mem[i] = $urandom;
            ref_mem[i]  = phys_mem[i];
        end
        phys_mem[32'h62 >> 2] = 32'hDEAD_BEEF;
        ref_mem[32'h62 >> 2]  = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_resp_a", bus.resp_a, 0);
        check_val("reset_pmem_read", bus.pmem_read, 0);
        check_val("reset_pmem_address", bus.pmem_address, 0);
        check_val("reset_err", bus.err, 0);
        rst_n = 1'b1;

        run_single(1'b0, 1'b0, 1'b0, 32'h62, '0, '0, 3, 1'b0, 1'b0);
        run_single(1'b1, 1'b1, 1'b0, 32'h100, 32'h1234_5678, 4'b0011, 2, 1'b0, 1'b0);
        run_single(1'b1, 1'b0, 1'b0, 32'h100, '0, '0, 1, 1'b0, 1'b0);
        run_single(1'b1, 1'b1, 1'b1, 32'h104, $urandom, 4'b1100, 2, 1'b0, 1'b0);
        run_single(1'b1, 1'b0, 1'b0, 32'h107, '0, '0, 4, 1'b0, 1'b0);
        run_contention(32'h20, 32'h24);

        for (int i = 0; i < 40; i++) begin
            bit pb, wr, rd2, de;
            logic [31:0] ad, wd;
            logic [3:0] wm;
            int unsigned l;
            pb  = 1'($urandom_range(0, 1));
            wr  = pb ? 1'($urandom_range(0, 1)) : 1'b0;
            rd2 = 1'($urandom_range(0, 1));
            de  = ($urandom_range(0, 3) == 0);
            ad  = 32'($urandom_range(0, 1023));
            wd  = $urandom;
            wm  = 4'($urandom_range(1, 15));
            l   = $urandom_range(1, 6);
            run_single(pb, wr, rd2, ad, wd, wm, l, de, 1'b0);
        end

        run_reset_mid_busy();
        run_single(1'b0, 1'b0, 1'b0, 32'h30, '0, '0, 2, 1'b0, 1'b0);

        mem_hang = 1'b1;
        run_single(1'b1, 1'b0, 1'b0, 32'h40, '0, '0, 1, 1'b0, 1'b1);
        mem_hang = 1'b0;
        run_single(1'b0, 1'b0, 1'b0, 32'h8, '0, '0, 2, 1'b0, 1'b0);

        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("err_cleared_by_reset", bus.err, 0);
        exp_err     = 1'b0;
        exp_rdata_a = '0;
        exp_rdata_b = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_single(1'b1, 1'b0, 1'b0, 32'h100, '0, '0, 3, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
